mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits (range 1-15).
REQ-002 CLK  in  1  clock; all state changes on rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 iREN  in  1  instruction fetch request.
REQ-005 iaddr  in  32  instruction address.
REQ-006 ihit  out  1  instruction transfer complete this cycle.
REQ-007 iload  out  32  instruction word, valid when ihit=1.
REQ-008 dREN  in  1  data read request.
REQ-009 dWEN  in  1  data write request.
REQ-010 daddr  in  32  data address.
REQ-011 dstore  in  32  data write value.
REQ-012 dhit  out  1  data transfer complete this cycle.
REQ-013 dload  out  32  data read value, valid when dhit=1 and dWEN=0.
REQ-014 ramREN  out  1  RAM read strobe.
REQ-015 ramWEN  out  1  RAM write strobe.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramready  in  1  RAM completes the current access this cycle.

Function
REQ-020 FSM states IDLE, DGRANT, IGRANT; one RAM port shared by fetch and data sides.
REQ-021 Data request = dREN|dWEN; dWEN takes precedence over dREN (write issued, ramREN=0).
REQ-022 IDLE: data request -> DGRANT; else iREN -> IGRANT; else stay; RAM strobes 0 in IDLE.
REQ-023 DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN, all combinational from current inputs.
REQ-024 IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-025 ihit=(state==IGRANT)&ramready&iREN; dhit=(state==DGRANT)&ramready&data request; both combinational, never both 1.
REQ-026 iload=ramload and dload=ramload pass through combinationally; value undefined when the matching hit is 0.
REQ-027 On completion, next state selected in the same edge by REQ-022 priority (no bubble cycle), subject to REQ-029.
REQ-028 4-bit counter dstreak: +1 on each dhit while iREN=1; cleared on ihit or when iREN=0; saturates at 15.
REQ-029 If dstreak reaches STARVE_MAX at a dhit and iREN=1, next state is IGRANT even with a data request pending.
REQ-030 Requester drops its request while granted (no ramready): abort, RAM strobes fall same cycle, next state IDLE, no hit.
REQ-031 Address/data changes mid-grant are forwarded to RAM without restarting; no latching of requester inputs.
REQ-032 Minimum latency: request at edge N, grant state at N+1, hit earliest in cycle after N+1 if ramready=1.
REQ-033 ramready in IDLE is ignored.

Reset
REQ-034 nRST=0 forces state=IDLE, dstreak=0 asynchronously; ramREN, ramWEN, ihit, dhit=0, ramaddr, ramstore=0 immediately.
REQ-035 Reset mid-grant aborts the access with no hit; first grant possible on the first edge after nRST rises.

Verification
REQ-036 Idle fetch: iREN=1, iaddr=0x40, ramready=1 after 2 cycles, ramload=0x8C010004 -> ramREN=1, ramaddr=0x40, one ihit pulse, iload=0x8C010004.
REQ-037 Simultaneous: iREN=1, dREN=1 daddr=0x100 from IDLE -> DGRANT first, dhit, then IGRANT with no idle cycle, ihit.
REQ-038 Write: dWEN=1, dREN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit on ramready.
REQ-039 Starvation, STARVE_MAX=4: data request held high, iREN=1, ramready=1 -> exactly 4 dhit, then 1 ihit, then data resumes.
REQ-040 Abort: IGRANT, ramready=0, iREN drops -> ramREN=0 same cycle, IDLE next, no ihit.
REQ-041 Reset mid-DGRANT with ramready=1 -> dhit=0 and ramWEN=0 immediately, state IDLE, dstreak=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one RAM port between an instruction fetch side and a data side.
// Data wins ties, but a waiting fetch is forced in after STARVE_MAX back-to-back data hits.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] dstreak;
    logic [4:0] streak_inc;
    logic       dreq;
    logic       starve;

    assign dreq       = dREN | dWEN;
    assign iload      = ramload;
    assign dload      = ramload;
    assign streak_inc = {1'b0, dstreak} + 5'd1;
    // True when the data hit completing this cycle uses up the fetch side's patience.
    assign starve     = iREN && (streak_inc >= 5'(STARVE_MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak <= 4'd0;
        end else if (!iREN || ihit) begin
            dstreak <= 4'd0;
        end else if (dhit && (dstreak != 4'hF)) begin
            dstreak <= dstreak + 4'd1;
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        dhit       = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'h0;
        ramstore   = 32'h0;
        case (state)
            IDLE: begin
                if (dreq) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dhit     = ramready & dreq;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (ramready) begin
                    next_state = starve ? IGRANT : DGRANT;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                // Strobe follows the request so a dropped fetch releases the RAM at once.
                ramREN  = iREN;
                ihit    = ramready & iREN;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ramready) begin
                    next_state = dreq ? DGRANT : IGRANT;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-level ownership model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_mem_arbiter;

    localparam int SM = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [65:0] outs;

    int    tests = 0;
    int    fails = 0;
    int    icnt  = 0;
    int    dcnt  = 0;
    bit    chk_en = 1'b0;
    bit    log_en = 1'b0;
    string hitlog = "";

    // Model: who owns the RAM port (0 nobody, 1 data side, 2 fetch side) and the data streak.
    int m_owner  = 0;
    int m_streak = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    assign outs = {ihit, dhit, ramREN, ramWEN, ramaddr, ramstore};

    function automatic int preferred();
        if (dREN | dWEN) return 1;
        if (iREN) return 2;
        return 0;
    endfunction

    function automatic int nxt_owner();
        logic dreq = dREN | dWEN;
        case (m_owner)
            0: return preferred();
            1: begin
                if (!dreq) return 0;
                if (!ramready) return 1;
                if (iREN && (m_streak + 1 >= SM)) return 2;
                return preferred();
            end
            2: begin
                if (!iREN) return 0;
                if (!ramready) return 2;
                return preferred();
            end
            default: return 0;
        endcase
    endfunction

    function automatic int nxt_streak();
        if (!iREN) return 0;
        if (m_owner == 2 && ramready) return 0;
        if (m_owner == 1 && ramready && (dREN | dWEN)) return (m_streak >= 15) ? 15 : m_streak + 1;
        return m_streak;
    endfunction

    function automatic logic [65:0] exp_out();
        logic dreq = dREN | dWEN;
        case (m_owner)
            1: return {1'b0, ramready & dreq, dREN & ~dWEN, dWEN, daddr, dstore};
            2: return {ramready & iREN, 1'b0, iREN, 1'b0, iaddr, 32'h0};
            default: return '0;
        endcase
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_owner  <= 0;
            m_streak <= 0;
        end else begin
            m_owner  <= nxt_owner();
            m_streak <= nxt_streak();
        end
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        logic [65:0] e;
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                e = exp_out();
                check("cycle_outputs", outs, e);
                if (e[65]) check("cycle_iload", iload, ramload);
                if (e[64] && !dWEN) check("cycle_dload", dload, ramload);
                if (ihit) icnt++;
                if (dhit) dcnt++;
                if (log_en) hitlog = {hitlog, ihit ? "i" : (dhit ? "d" : "-")};
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        {iREN, dREN, dWEN, ramready} = 4'b0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        nRST = 1'b1;
        #2 nRST = 1'b0;
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h55; dstore = 32'h77; ramready = 1'b1;
        #1 chk_en = 1'b1;
        check("reset_outputs", outs, '0);
        #9;
        iREN = 1'b0; dWEN = 1'b0; ramready = 1'b0; daddr = 0; dstore = 0;
        nRST = 1'b1;
        cyc(1);

        // Idle fetch
        icnt = 0;
        iREN = 1'b1; iaddr = 32'h40; ramload = 32'h8C010004;
        cyc(1);
        check("fetch_grant", {ramREN, ramaddr}, {1'b1, 32'h40});
        check("fetch_wait_nohit", ihit, 0);
        cyc(1);
        ramready = 1'b1;
        #1;
        check("fetch_hit", ihit, 1);
        check("fetch_iload", iload, 32'h8C010004);
        cyc(1);
        iREN = 1'b0; ramready = 1'b0;
        cyc(2);
        check("fetch_pulses", icnt, 1);

        // Data write, with address forwarded mid-grant
        dcnt = 0;
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        cyc(1);
        check("wr_strobes", {ramWEN, ramREN}, 2'b10);
        check("wr_store", ramstore, 32'hDEADBEEF);
        check("wr_addr", ramaddr, 32'h200);
        daddr = 32'h204;
        #1;
        check("wr_addr_fwd", ramaddr, 32'h204);
        ramready = 1'b1;
        #1;
        check("wr_dhit", dhit, 1);
        cyc(1);
        dWEN = 1'b0; dREN = 1'b0; ramready = 1'b0;
        cyc(2);
        check("wr_pulses", dcnt, 1);

        // Simultaneous requests, then starvation relief with no idle cycle
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
        ramready = 1'b1; ramload = 32'h11112222;
        #1;
        check("idle_ignores_ready", {ramREN, ramWEN, ihit, dhit}, 4'b0);
        cyc(1);
        check("sim_dgrant_first", {ramREN, ramaddr}, {1'b1, 32'h100});
        hitlog = ""; log_en = 1'b1;
        cyc(8);
        log_en = 1'b0;
        check_str("starve_sequence", hitlog, "ddddiddd");
        dREN = 1'b0; iREN = 1'b0; ramready = 1'b0;
        cyc(2);

        // Fetch abort, then ramready while idle
        icnt = 0;
        iREN = 1'b1; iaddr = 32'h300;
        cyc(1);
        check("abort_grant", {ramREN, ramaddr}, {1'b1, 32'h300});
        iaddr = 32'h304;
        #1;
        check("iaddr_fwd", ramaddr, 32'h304);
        iREN = 1'b0;
        #1;
        check("abort_strobe", {ramREN, ihit}, 2'b00);
        cyc(1);
        ramready = 1'b1;
        #1;
        check("abort_idle", outs, '0);
        cyc(1);
        ramready = 1'b0;
        check("abort_no_ihit", icnt, 0);

        // Reset in the middle of a write grant; the streak must restart from zero
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h400; dstore = 32'hCAFE;
        ramready = 1'b1;
        cyc(3);
        #1;
        check("pre_reset_dhit", {dhit, ramWEN}, 2'b11);
        #1 nRST = 1'b0;
        #1;
        check("reset_mid_grant", outs, '0);
        #3 nRST = 1'b1;
        cyc(1);
        hitlog = ""; log_en = 1'b1;
        cyc(5);
        log_en = 1'b0;
        check_str("streak_cleared", hitlog, "ddddi");
        iREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
        cyc(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
